// File: rtl/sfc_pkg.sv
// Shared types and widths for the serial frame capture block.
package sfc_pkg;
    localparam int BYTE_W     = 8;
    localparam int CHECKSUM_W = 16;

    typedef enum logic {
        IDLE,
        RECV
    } state_t;
endpackage

// File: rtl/sfc_deser8.sv
// 1-bit to byte deserializer: MSB-first shift register, bit counter, output
// register and the upstream ready.
module sfc_deser8
    import sfc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              serial_data,
    input  logic              serial_valid,
    output logic              serial_ready,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic [2:0]        bit_cnt
);
    logic [BYTE_W-2:0] sr;
    logic              completing;
    logic              bit_xfer;
    logic              byte_xfer;

    assign completing = (bit_cnt == 3'd7);
    // Only the completing bit can stall; it needs the output register free.
    assign serial_ready = !clear && !(completing && byte_valid && !byte_ready);
    assign bit_xfer     = serial_valid && serial_ready;
    assign byte_xfer    = byte_valid && byte_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= '0;
            bit_cnt    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
        end else if (clear) begin
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
        end else begin
            if (byte_xfer)
                byte_valid <= 1'b0;
            // A load in the same cycle as a hand-off keeps byte_valid high.
            if (bit_xfer) begin
                if (completing) begin
                    byte_data  <= {sr, serial_data};
                    byte_valid <= 1'b1;
                    bit_cnt    <= '0;
                end else begin
                    sr      <= {sr[BYTE_W-3:0], serial_data};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end
endmodule

// File: rtl/serial_frame_capture.sv
// Serial-to-byte frame capture: byte/frame counting, last-byte flag, frame_done.
// Optional per-frame byte checksum when SFC_CHECKSUM_EN is defined.
module serial_frame_capture
    import sfc_pkg::*;
#(
    parameter int PIXELS_PER_FRAME = 1024,
    parameter int FRAME_CNT_W      = 16
) (
    input  logic                   clk_200mhz,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   serial_data,
    input  logic                   serial_valid,
    output logic                   serial_ready,
    output logic [BYTE_W-1:0]      byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   byte_last,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [CHECKSUM_W-1:0]  checksum
);
    localparam int               CNT_W    = $clog2(PIXELS_PER_FRAME);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS_PER_FRAME - 1);

    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic             bit_xfer;
    logic             byte_xfer;
    logic             last_xfer;
    state_t           state;

    sfc_deser8 u_deser (
        .clk         (clk_200mhz),
        .rst_n       (reset_n),
        .clear       (clear),
        .serial_data (serial_data),
        .serial_valid(serial_valid),
        .serial_ready(serial_ready),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .bit_cnt     (bit_cnt)
    );

    assign bit_xfer  = serial_valid && serial_ready;
    assign byte_xfer = byte_valid && byte_ready && !clear;
    assign byte_last = (byte_cnt == LAST_IDX);
    assign last_xfer = byte_xfer && byte_last;

    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt    <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            state       <= IDLE;
        end else begin
            frame_done <= last_xfer;
            if (clear) begin
                byte_cnt <= '0;
                state    <= IDLE;
            end else begin
                if (byte_xfer)
                    byte_cnt <= byte_last ? '0 : byte_cnt + 1'b1;
                if (last_xfer)
                    frame_count <= frame_count + FRAME_CNT_W'(1);
                case (state)
                    IDLE: if (bit_xfer) state <= RECV;
                    // Any bit of the next frame already in flight keeps us in RECV.
                    RECV: if (last_xfer && bit_cnt == 3'd0 && !bit_xfer) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SFC_CHECKSUM_EN
    logic [CHECKSUM_W-1:0] acc;
    logic [CHECKSUM_W-1:0] sum_next;

    assign sum_next = acc + CHECKSUM_W'(byte_data);

    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            checksum <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (byte_xfer) begin
            if (byte_last) begin
                checksum <= sum_next;
                acc      <= '0;
            end else begin
                acc <= sum_next;
            end
        end
    end
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_serial_frame_capture.sv
// Directed bench for serial_frame_capture (PIXELS_PER_FRAME=4) with a byte
// scoreboard and a small frame/checksum model checked every cycle.
module tb_serial_frame_capture;
    localparam int PPF = 4;

    logic        clk_200mhz = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        serial_data;
    logic        serial_valid;
    logic        serial_ready;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [15:0] checksum;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  q[$];
    int          pos;
    logic [15:0] acc_sum;
    logic [15:0] cks_m;
    logic [15:0] fc_m;
    logic        done_pend;
    logic        sr_s, bv_s, acc_s;
    int          stalls;
    int          done_cnt;
    int          d0;

    serial_frame_capture #(.PIXELS_PER_FRAME(PPF), .FRAME_CNT_W(16)) dut (
        .clk_200mhz  (clk_200mhz),
        .reset_n     (reset_n),
        .clear       (clear),
        .serial_data (serial_data),
        .serial_valid(serial_valid),
        .serial_ready(serial_ready),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_last   (byte_last),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .checksum    (checksum)
    );

    always #5 clk_200mhz = ~clk_200mhz;

    function automatic logic [15:0] exp_cks();
`ifdef SFC_CHECKSUM_EN
        return cks_m;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pos = 0; acc_sum = '0; cks_m = '0; fc_m = '0; done_pend = 1'b0;
    endtask

    // One clock: drive, sample/check at negedge, advance to just past posedge.
    task automatic step(input logic d, input logic v);
        logic [7:0] e;
        serial_data  = d;
        serial_valid = v;
        @(negedge clk_200mhz);
        sr_s  = serial_ready;
        bv_s  = byte_valid;
        acc_s = serial_valid && serial_ready;
        chk("frame_done", frame_done, done_pend);
        chk("frame_count", frame_count, fc_m);
        chk("checksum", checksum, exp_cks());
        if (frame_done) done_cnt++;
        done_pend = 1'b0;
        if (clear) begin
            chk("ready_in_clear", serial_ready, 1'b0);
            q.delete();
            pos = 0;
            acc_sum = '0;
        end else if (byte_valid && byte_ready) begin
            chk("byte_unexpected", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("byte_data", byte_data, e);
                chk("byte_last", byte_last, pos == PPF - 1);
                acc_sum = acc_sum + 16'(e);
                if (pos == PPF - 1) begin
                    pos = 0; done_pend = 1'b1; fc_m = fc_m + 16'd1;
                    cks_m = acc_sum; acc_sum = '0;
                end else begin
                    pos++;
                end
            end
        end
        @(posedge clk_200mhz);
        #1;
    endtask

    task automatic send_bit(input logic d);
        int n;
        n = 0;
        step(d, 1'b1);
        while (!acc_s && n < 20) begin
            stalls++; n++;
            step(d, 1'b1);
        end
        chk("bit_timeout", acc_s, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        q.push_back(b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, serial_ready, 1'b1);
        chk({tag, "_data"}, byte_data, 8'h00);
        chk({tag, "_valid"}, byte_valid, 1'b0);
        chk({tag, "_last"}, byte_last, 1'b0);
        chk({tag, "_done"}, frame_done, 1'b0);
        chk({tag, "_count"}, frame_count, 16'h0000);
        chk({tag, "_cks"}, checksum, 16'h0000);
    endtask

    initial begin
        logic [7:0] b;
        reset_n = 1'b0; clear = 1'b0; serial_data = 1'b0; serial_valid = 1'b0;
        byte_ready = 1'b0; stalls = 0; done_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk_200mhz);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        // Single byte 0xA5, downstream always ready.
        byte_ready = 1'b1;
        send_byte(8'hA5);
        chk("valid_at_8th_bit", bv_s, 1'b0);
        step(1'b0, 1'b0);
        chk("valid_latency", bv_s, 1'b1);
        chk("a5_no_stall", stalls, 0);
        idle(1);

        // Backpressure: stall lands exactly on the 8th bit of the second byte.
        byte_ready = 1'b0;
        send_byte(8'h3C);
        b = 8'hC3;
        q.push_back(b);
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        chk("bits_0_6_no_stall", stalls, 0);
        step(b[0], 1'b1);
        chk("stall_8th_bit", sr_s, 1'b0);
        step(b[0], 1'b1);
        chk("stall_held", sr_s, 1'b0);
        byte_ready = 1'b1;
        send_bit(b[0]);
        send_byte(8'h5A);
        idle(3);
        chk("frame0_count", frame_count, 16'd1);

        // Back-to-back frame 01..04.
        d0 = done_cnt;
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        idle(3);
        chk("frame1_count", frame_count, 16'd2);
        chk("frame1_done_pulses", done_cnt - d0, 1);
`ifdef SFC_CHECKSUM_EN
        chk("frame1_cks", checksum, 16'h000A);
`endif

        // Three frames of 0xFF with no gaps.
        stalls = 0; d0 = done_cnt;
        for (int i = 0; i < 3 * PPF; i++) send_byte(8'hFF);
        idle(3);
        chk("ff_count", frame_count, 16'd5);
        chk("ff_done_pulses", done_cnt - d0, 3);
        chk("ff_no_stall", stalls, 0);
`ifdef SFC_CHECKSUM_EN
        chk("ff_cks", checksum, 16'h03FC);
`endif

        // Clear after 5 bits of byte 2.
        send_byte(8'h11);
        send_byte(8'h22);
        b = 8'h33;
        q.push_back(b);
        for (int i = 7; i >= 3; i--) send_bit(b[i]);
        clear = 1'b1;
        step(b[2], 1'b1);
        clear = 1'b0;
        step(1'b0, 1'b0);
        chk("clear_valid", bv_s, 1'b0);
        chk("clear_count_kept", frame_count, 16'd5);
        for (int i = 1; i <= 4; i++) send_byte(8'(i * 16));
        idle(3);
        chk("post_clear_count", frame_count, 16'd6);
`ifdef SFC_CHECKSUM_EN
        chk("post_clear_cks", checksum, 16'h00A0);
`endif

        // Asynchronous reset mid-byte while a byte is held.
        byte_ready = 1'b0;
        send_byte(8'h77);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("held_valid", byte_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        @(posedge clk_200mhz);
        #1;
        reset_n = 1'b1;
        byte_ready = 1'b1;
        send_byte(8'h80); send_byte(8'h01); send_byte(8'hF0); send_byte(8'h0F);
        idle(3);
        chk("post_rst_count", frame_count, 16'd1);
`ifdef SFC_CHECKSUM_EN
        chk("post_rst_cks", checksum, 16'h0180);
`endif
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_frame_capture.md
# serial_frame_capture

Receive-side stage directly downstream of the parallel-to-serial converter: consumes the 1-bit `serial_data`/`serial_valid` stream, drives its `serial_ready_in`, reassembles MSB-first bytes of pooled pixel data and presents them on a valid/ready byte interface. It counts bytes per frame, flags the last byte, and pulses `frame_done` with a running frame count. Runs entirely in the 200 MHz domain.

## Interface
- `PIXELS_PER_FRAME`, 1024, bytes per frame (≥2).
- `FRAME_CNT_W`, 16, width of the completed-frame counter.
- `clk_200mhz` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous abort; discards partial byte and partial frame.
- `serial_data` input 1: serial bit, MSB of each byte first.
- `serial_valid` input 1: bit on `serial_data` is valid.
- `serial_ready` output 1: block accepts a bit this cycle; connects to the converter's `serial_ready_in`.
- `byte_data` output 8: assembled byte.
- `byte_valid` output 1: `byte_data` valid.
- `byte_ready` input 1: downstream accepts byte.
- `byte_last` output 1: qualifies the final byte of a frame; meaningful only while `byte_valid`.
- `frame_done` output 1: one-cycle pulse when the last byte of a frame is handed off.
- `frame_count` output FRAME_CNT_W: completed frames, wraps modulo 2^FRAME_CNT_W.
- `checksum` output 16: frame byte sum; see Configuration.

## Operation
- Bit transfer = `serial_valid && serial_ready` on a rising edge. Byte transfer = `byte_valid && byte_ready`.
- Shift register `sr[6:0]` and 3-bit `bit_cnt`; each bit transfer shifts in left, `bit_cnt++`.
- On the 8th bit (`bit_cnt==7`), `{sr,serial_data}` is loaded into the output register, `byte_valid` is set, and `bit_cnt` returns to 0.
- `serial_ready = !(bit_cnt==7 && byte_valid && !byte_ready)`: stall only when the completing bit has nowhere to go. Bits 0–6 are always accepted. Combinational from `byte_ready`.
- Simultaneous byte hand-off and new byte load in the same cycle: the output register takes the new byte, and `byte_valid` stays 1.
- `byte_cnt` (clog2(PIXELS_PER_FRAME) bits) counts byte transfers. `byte_last = (byte_cnt == PIXELS_PER_FRAME-1)`.
  - On the last byte transfer: `byte_cnt` goes to 0, `frame_done` pulses, and `frame_count` increments.
- State machine:
  - IDLE: `bit_cnt==0` and `byte_cnt==0`. Moves to RECV on the first bit transfer.
  - RECV: frame in progress. Moves to IDLE on the last byte transfer when no partial byte is pending. Otherwise stays in RECV, and the next frame begins immediately.
- `clear` has priority over all transfers that cycle:
  - Zeroes `bit_cnt`, `byte_cnt`, `byte_valid` and the checksum accumulator.
  - Does not change `frame_count`.
  - Forces `serial_ready=0` for that cycle. State goes to IDLE.

## Timing
- Reset values: `serial_ready`=1, `byte_data`=0, `byte_valid`=0, `byte_last`=0, `frame_done`=0, `frame_count`=0, `checksum`=0; state IDLE.
- Latency: `byte_valid` rises the cycle after the 8th bit transfer. `frame_done` and the `frame_count` update are registered, visible the cycle after the last byte transfer.
- Sustained throughput is 1 bit/cycle with `byte_ready` held high, with no bubbles between bytes or frames.
- Reset mid-byte or mid-frame: all state is discarded asynchronously. The first bit after release is treated as the MSB of byte 0.

## Configuration
- `SFC_CHECKSUM_EN` defined:
  - A 16-bit accumulator adds each transferred byte, modulo 2^16.
  - On the last byte transfer, `checksum` is loaded with the final sum (including the last byte) and the accumulator is cleared. `checksum` holds until the next frame completes.
- Undefined: `checksum` is tied to 0 and no accumulator is synthesized.

## Structure
- Shared package `sfc_pkg`: state enum (IDLE, RECV), `BYTE_W=8`, `CHECKSUM_W=16`.
- One sub-module, `sfc_deser8`: shift register, `bit_cnt`, output register and ready logic. The top level holds the frame counting, FSM and checksum.

## Test plan
- Reset, then bits of 0xA5 (1,0,1,0,0,1,0,1) with `byte_ready`=1 -> `byte_data`=0xA5, `byte_valid` high one cycle after the 8th bit, `serial_ready` always 1.
- `byte_ready`=0 while two bytes 0x3C, 0xC3 are streamed -> `serial_ready` drops exactly at the 8th bit of 0xC3. Raising `byte_ready` delivers 0x3C, then 0xC3. No bit is lost.
- PIXELS_PER_FRAME=4, bytes 0x01,0x02,0x03,0x04 back-to-back -> `byte_last` only on 0x04, one `frame_done` pulse, `frame_count`=1. With `SFC_CHECKSUM_EN`, `checksum`=0x000A.
- Three frames of 256×0xFF with PIXELS_PER_FRAME=256 -> `frame_count`=3, `checksum`=0xFF00 after each frame, no idle cycles between frames.
- `clear` after 5 bits of byte 2 -> `byte_valid`=0 and the next byte starts at the MSB; the following full frame reports `byte_last` on its 4th byte (PIXELS_PER_FRAME=4); `frame_count` unchanged by the clear.
- Assert `reset_n`=0 mid-byte with `byte_valid`=1 -> all outputs at reset values asynchronously, before the next clock edge.
